// File: rtl/flash_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flash_read_ctrl
// Purpose  : SPI-flash 4-byte-address read initiator (mode 0) with a byte
//            strobe output. Define FLASH_READ_FAST_EN for Fast Read (0x0C)
//            with 8 dummy clocks.
// Revision : 1.0  initial release
// ============================================================================
module flash_read_ctrl #(
  parameter int RD_LEN      = 16,
  parameter int CLK_HALF    = 2,
  parameter int CS_HIGH_CYC = 8
) (
  input  logic        system_clk,
  input  logic        system_reset_n,
  input  logic        key,
  input  logic [31:0] addr,
  output logic        cs_n,
  output logic        spi_clk,
  inout  wire         io0,
  input  logic        io1,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_done,
  output logic        busy
);

`ifdef FLASH_READ_FAST_EN
  localparam logic [7:0] c_cmd = 8'h0C;
`else
  localparam logic [7:0] c_cmd = 8'h13;
`endif

  localparam int c_div_w  = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int c_byte_w = (RD_LEN > 1) ? $clog2(RD_LEN) : 1;
  localparam int c_cnt_w  = (CS_HIGH_CYC > 0) ? $clog2(CS_HIGH_CYC + 1) : 1;

  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CLK_HALF - 1);
  localparam logic [c_byte_w-1:0] c_byte_last = c_byte_w'(RD_LEN - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(CS_HIGH_CYC - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_end   = c_cnt_w'(CS_HIGH_CYC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
`ifdef FLASH_READ_FAST_EN
    S_DUMMY = 3'd3,
`endif
    S_READ  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_div_w-1:0]  r_div;
  logic                r_sclk;
  logic [4:0]          r_bit;
  logic [c_byte_w-1:0] r_byte;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [39:0]         r_tx;
  logic                r_oe;
  logic [6:0]          r_shift;
  logic                r_cs_n;
  logic [7:0]          r_data;
  logic                r_valid;
  logic                r_done;

  logic w_active;
  logic w_half_end;
  logic w_rise;
  logic w_fall;
  logic w_phase_last;
  logic w_last_byte;

  assign w_active     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_half_end   = (r_div == c_div_last);
  assign w_rise       = w_active && !r_sclk && w_half_end;
  assign w_fall       = w_active && r_sclk && w_half_end;
  // ADDR is the only 32-bit phase; every other phase (and each READ byte) is 8 bits
  assign w_phase_last = (r_state == S_ADDR) ? (r_bit == 5'd31) : (r_bit == 5'd7);
  assign w_last_byte  = (r_byte == c_byte_last);

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (key) w_state_nxt = S_CMD;
      S_CMD:  if (w_fall && w_phase_last) w_state_nxt = S_ADDR;
`ifdef FLASH_READ_FAST_EN
      S_ADDR:  if (w_fall && w_phase_last) w_state_nxt = S_DUMMY;
      S_DUMMY: if (w_fall && w_phase_last) w_state_nxt = S_READ;
`else
      S_ADDR:  if (w_fall && w_phase_last) w_state_nxt = S_READ;
`endif
      S_READ: if (w_fall && w_phase_last && w_last_byte) w_state_nxt = S_DONE;
      S_DONE: if (r_cnt == c_cnt_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_div   <= '0;
      r_sclk  <= 1'b0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_cnt   <= '0;
      r_tx    <= '0;
      r_oe    <= 1'b0;
      r_shift <= '0;
      r_cs_n  <= 1'b1;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_div  <= '0;
          r_sclk <= 1'b0;
          r_cnt  <= '0;
          if (key) begin
            r_tx   <= {c_cmd, addr};
            r_oe   <= 1'b1;
            r_cs_n <= 1'b0;
            r_bit  <= '0;
            r_byte <= '0;
          end
        end
        S_DONE: begin
          // rd_done fires on the last high count; the following edge returns to IDLE
          r_cnt  <= r_cnt + 1'b1;
          r_done <= (r_cnt == c_cnt_last);
        end
        default: begin
          r_div <= w_half_end ? '0 : r_div + 1'b1;
          if (w_half_end) r_sclk <= ~r_sclk;
          if (w_rise && (r_state == S_READ)) begin
            r_shift <= {r_shift[5:0], io1};
            if (r_bit == 5'd7) begin
              r_data  <= {r_shift, io1};
              r_valid <= 1'b1;
            end
          end
          if (w_fall) begin
            r_tx  <= {r_tx[38:0], 1'b0};
            r_bit <= w_phase_last ? '0 : r_bit + 5'd1;
            if ((r_state == S_ADDR) && w_phase_last) r_oe <= 1'b0;
            // cs_n rises on the same edge that drops spi_clk after the final bit
            if ((r_state == S_READ) && w_phase_last) begin
              if (w_last_byte) r_cs_n <= 1'b1;
              else             r_byte <= r_byte + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign io0      = r_oe ? r_tx[39] : 1'bz;
  assign cs_n     = r_cs_n;
  assign spi_clk  = r_sclk;
  assign rd_data  = r_data;
  assign rd_valid = r_valid;
  assign rd_done  = r_done;
  assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_flash_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_read_ctrl
// Purpose  : Randomised scoreboard bench for flash_read_ctrl with a
//            behavioural SPI flash model (honours FLASH_READ_FAST_EN).
// Revision : 1.0  initial release
// ============================================================================
module tb_flash_read_ctrl;

  localparam int RD_LEN      = 4;
  localparam int CLK_HALF    = 2;
  localparam int CS_HIGH_CYC = 8;
`ifdef FLASH_READ_FAST_EN
  localparam int         DUMMY_BITS = 8;
  localparam logic [7:0] EXP_CMD    = 8'h0C;
`else
  localparam int         DUMMY_BITS = 0;
  localparam logic [7:0] EXP_CMD    = 8'h13;
`endif
  localparam int HDR_BITS   = 40 + DUMMY_BITS;
  localparam int EXP_PULSES = HDR_BITS + 8 * RD_LEN;
  localparam int EXP_LAT    = (HDR_BITS + 8) * 2 * CLK_HALF - CLK_HALF;
  localparam int TX_CYCLES  = EXP_PULSES * 2 * CLK_HALF + CS_HIGH_CYC + 2;
  localparam int HOLD_CYC   = 500;

  logic        system_clk = 1'b0;
  logic        system_reset_n;
  logic        key;
  logic [31:0] addr;
  logic        cs_n;
  logic        spi_clk;
  wire         io0;
  logic        io1 = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_done;
  logic        busy;

  flash_read_ctrl #(
    .RD_LEN      (RD_LEN),
    .CLK_HALF    (CLK_HALF),
    .CS_HIGH_CYC (CS_HIGH_CYC)
  ) dut (
    .system_clk     (system_clk),
    .system_reset_n (system_reset_n),
    .key            (key),
    .addr           (addr),
    .cs_n           (cs_n),
    .spi_clk        (spi_clk),
    .io0            (io0),
    .io1            (io1),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_done        (rd_done),
    .busy           (busy)
  );

  always #5 system_clk = ~system_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [256];
  logic [7:0]  exp_q [$];
  logic [39:0] hdr_q [$];

  int   cyc = 0;
  int   start_cyc = 0;
  int   starts = 0;
  int   dones = 0;
  int   cs_falls = 0;
  int   valid_seen = 0;
  bit   first_pend = 0;
  bit   aborted = 1;
  logic key_at_edge = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: a transaction starts at any edge where key is high and the block is idle
  always @(posedge system_clk) begin
    logic [31:0] a;
    cyc++;
    key_at_edge = key;
    if (system_reset_n && key && !busy) begin
      starts++;
      start_cyc  = cyc;
      first_pend = 1;
      aborted    = 0;
      hdr_q.push_back({EXP_CMD, addr});
      for (int i = 0; i < RD_LEN; i++) begin
        a = addr + 32'(i);
        exp_q.push_back(mem[a[7:0]]);
      end
    end
  end

  // Flash model: captures command/address, returns mem[] contents MSB first
  int          fbits = 0;
  int          zbad = 0;
  logic [39:0] hdr_cap = '0;
  logic [31:0] cap_addr = '0;

  always @(negedge cs_n) begin
    fbits = 0;
    zbad  = 0;
  end

  always @(posedge spi_clk) begin
    if (cs_n === 1'b0) begin
      if (fbits < 40) hdr_cap = {hdr_cap[38:0], io0};
      else if (io0 !== 1'bz) zbad++;
      fbits++;
      if (fbits == 40) begin
        cap_addr = hdr_cap[31:0];
        if (hdr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_addr: actual=%0h expected=none", hdr_cap);
        end else begin
          chk("cmd_addr", hdr_cap, hdr_q.pop_front());
        end
      end
    end
  end

  always @(negedge spi_clk) begin
    int          idx;
    logic [31:0] fa;
    logic [7:0]  fb;
    if (cs_n === 1'b0 && fbits >= HDR_BITS) begin
      idx = fbits - HDR_BITS;
      fa  = cap_addr + 32'(idx / 8);
      fb  = mem[fa[7:0]];
      io1 = fb[3'(7 - idx % 8)];
    end else if (cs_n === 1'b0 && fbits >= 40) begin
      io1 = 1'($urandom);
    end
  end

  always @(posedge cs_n) begin
    if (!aborted) begin
      chk("spi_pulses", fbits, EXP_PULSES);
      chk("io0_released", zbad, 0);
    end
  end

  // Monitor: data scoreboard plus pin-timing rules
  logic prev_rst = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b0, prev_io0 = 1'bz;
  logic prev_done = 1'b0, prev_busy = 1'b0;
  bit   done_pend = 0, fell_prev = 0;
  int   cs_rise_cyc = 0, run = 0;
  int   cs_viol = 0, io0_viol = 0, sclk_viol = 0;

  always @(negedge system_clk) begin
    if (rd_valid === 1'b1) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_data: actual=%0h expected=none (unexpected rd_valid)", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
      if (first_pend) begin
        chk("first_valid_latency", cyc - start_cyc, EXP_LAT);
        first_pend = 0;
      end
    end
    if (prev_rst && system_reset_n) begin
      if (cs_n === 1'b0 && prev_cs === 1'b1) cs_falls++;
      if (cs_n === 1'b1 && prev_cs === 1'b0) begin
        cs_rise_cyc = cyc;
        done_pend   = 1;
      end
      if (cs_n !== prev_cs && spi_clk !== 1'b0) cs_viol++;
      if (io0 !== prev_io0 &&
          !((prev_sclk === 1'b1 && spi_clk === 1'b0) ||
            (prev_cs === 1'b1 && cs_n === 1'b0))) io0_viol++;
      if (spi_clk !== prev_sclk) begin
        if (prev_cs === 1'b0 && run != CLK_HALF) sclk_viol++;
        run = 1;
      end else if (cs_n === 1'b0 && prev_cs === 1'b1) begin
        run = 1;
      end else begin
        run++;
      end
      if (rd_done === 1'b1) begin
        dones++;
        chk("busy_during_done", busy, 1'b1);
        if (done_pend) chk("done_after_cs_high", cyc - cs_rise_cyc, CS_HIGH_CYC);
        done_pend = 0;
      end
      if (prev_done === 1'b1) chk("idle_after_done", {busy, rd_done}, 2'b00);
      if (fell_prev && key_at_edge) chk("restart_after_idle", {busy, cs_n}, 2'b10);
      fell_prev = (prev_busy === 1'b1 && busy === 1'b0);
    end else begin
      run       = 0;
      fell_prev = 0;
    end
    prev_rst  = system_reset_n;
    prev_cs   = cs_n;
    prev_sclk = spi_clk;
    prev_io0  = io0;
    prev_done = rd_done;
    prev_busy = busy;
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge system_clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_idle: actual=busy after %0d cycles required=idle", n);
    end
  endtask

  task automatic run_tx(input logic [31:0] a, input int width);
    @(negedge system_clk);
    addr = a;
    key  = 1'b1;
    repeat (width) @(negedge system_clk);
    key  = 1'b0;
    addr = $urandom;
    wait_idle(2 * TX_CYCLES);
    repeat ($urandom_range(0, 3)) @(negedge system_clk);
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_cs_n"},     cs_n,     1'b1);
    chk({tag, "_spi_clk"},  spi_clk,  1'b0);
    chk({tag, "_io0"},      io0,      1'bz);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_rd_done"},  rd_done,  1'b0);
    chk({tag, "_busy"},     busy,     1'b0);
    chk({tag, "_rd_data"},  rd_data,  8'h00);
  endtask

  initial begin
    int s0;
    int v0;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h45] = 8'hA5;
    mem[8'h46] = 8'h3C;
    mem[8'h47] = 8'hFF;
    mem[8'h48] = 8'h00;

    system_reset_n = 1'b0;
    key  = 1'b0;
    addr = '0;
    repeat (3) @(negedge system_clk);
    check_reset_pins("reset");
    system_reset_n = 1'b1;
    repeat (2) @(negedge system_clk);

    run_tx(32'h0001_2345, 1);
    run_tx(32'hFFFF_FFFF, 1);
    for (int t = 0; t < 6; t++) run_tx($urandom, $urandom_range(1, 4));

    // key held high: one transaction per idle window, address resampled only at start
    s0 = starts;
    @(negedge system_clk);
    key = 1'b1;
    repeat (HOLD_CYC) begin
      @(negedge system_clk);
      addr = $urandom;
    end
    key = 1'b0;
    wait_idle(2 * TX_CYCLES);
    chk("starts_during_hold", starts - s0, (HOLD_CYC - 1) / TX_CYCLES + 1);

    // asynchronous reset while the second byte is on the wire
    v0 = valid_seen;
    @(negedge system_clk);
    addr = $urandom;
    key  = 1'b1;
    @(negedge system_clk);
    key = 1'b0;
    n = 0;
    while (valid_seen == v0 && n < 2 * TX_CYCLES) begin
      @(negedge system_clk);
      n++;
    end
    chk("first_byte_before_reset", valid_seen - v0, 1);
    repeat (10) @(negedge system_clk);
    #2;
    aborted = 1;
    system_reset_n = 1'b0;
    #1;
    check_reset_pins("midreset");
    exp_q.delete();
    hdr_q.delete();
    first_pend = 0;
    done_pend  = 0;
    repeat (3) @(negedge system_clk);
    system_reset_n = 1'b1;
    repeat (2) @(negedge system_clk);

    run_tx($urandom, 1);
    run_tx($urandom, 2);
    repeat (5) @(negedge system_clk);

    chk("bytes_outstanding", exp_q.size(), 0);
    chk("cs_n_falls", cs_falls, starts);
    chk("rd_done_count", dones, starts - 1);
    chk("cs_n_change_with_sclk_low", cs_viol, 0);
    chk("io0_change_on_falling_only", io0_viol, 0);
    chk("spi_clk_half_periods", sclk_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=not finished required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
